// File: rtl/bypass_wire_multi_pkg.sv
// Shared constants and helpers for the multi-channel bypass wire.
package bypass_wire_multi_pkg;

  localparam int unsigned BW_MAX_STAGES = 4;
  localparam int unsigned BW_MAX_NCH    = 32;

  // LSB of channel c inside a packed nch*width bus
  function automatic int unsigned chan_lsb(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/bypass_wire_multi_if.sv
// Packed per-channel strobe/data bus between a producer and the bypass wire block.
interface bypass_wire_multi_if #(
  parameter int unsigned width = 1,
  parameter int unsigned nch   = 1
);

  logic [nch-1:0]       wset;
  logic [nch*width-1:0] wval;
  logic [nch*width-1:0] wget;
  logic [nch-1:0]       whas;
  logic [nch-1:0]       wchg;

  modport master (output wset, output wval, input wget, input whas, input wchg);
  modport slave  (input wset, input wval, output wget, output whas, output wchg);

endinterface

// File: rtl/bypass_wire_chan.sv
// One channel: optional {valid,data} delay line, hold register and registered change pulse.
module bypass_wire_chan #(
  parameter int unsigned     width  = 1,
  parameter int unsigned     stages = 0,
  parameter bit              hold   = 1'b1,
  parameter logic [width-1:0] init  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wset,
  input  logic [width-1:0] wval,
  output logic [width-1:0] wget,
  output logic             whas,
  output logic             wchg
);

  localparam int NSTG = int'(stages);
  localparam int LAST = NSTG - 1;

  logic             po_v;
  logic [width-1:0] po_d;
  logic [width-1:0] hreg;
  logic             chg_q;

  // Free-running delay line; data only moves with a valid write
  for (genvar i = 0; i < NSTG; i++) begin : g_stage
    logic             v_in;
    logic [width-1:0] d_in;
    logic             v_q;
    logic [width-1:0] d_q;

    if (i == 0) begin : g_first
      assign v_in = wset;
      assign d_in = wval;
    end else begin : g_next
      assign v_in = g_stage[i-1].v_q;
      assign d_in = g_stage[i-1].d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_in;
        if (v_in) d_q <= d_in;
      end
    end
  end

  if (NSTG == 0) begin : g_bypass
    assign po_v = wset;
    assign po_d = wval;
  end else begin : g_piped
    assign po_v = g_stage[LAST].v_q;
    assign po_d = g_stage[LAST].d_q;
  end

  // Change detect compares against the value held before this write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hreg  <= init;
      chg_q <= 1'b0;
    end else begin
      chg_q <= po_v && (po_d != hreg);
      if (po_v) hreg <= po_d;
    end
  end

  assign whas = po_v;
  assign wchg = chg_q;
  assign wget = po_v ? po_d : (hold ? hreg : '0);

endmodule

// File: rtl/bypass_wire_multi.sv
// NCH independent bypass wire channels with programmable depth, hold and change pulse.
module bypass_wire_multi
  import bypass_wire_multi_pkg::*;
#(
  parameter int unsigned      width  = 1,
  parameter int unsigned      nch    = 1,
  parameter int unsigned      stages = 0,
  parameter bit               hold   = 1'b1,
  parameter logic [width-1:0] init   = '0
) (
  input logic                clk,
  input logic                rst_n,
  bypass_wire_multi_if.slave bus
);

  if (stages > BW_MAX_STAGES) begin : g_bad_stages
    $error("bypass_wire_multi: stages=%0d exceeds %0d", stages, BW_MAX_STAGES);
  end
  if (nch < 1 || nch > BW_MAX_NCH) begin : g_bad_nch
    $error("bypass_wire_multi: nch=%0d outside 1..%0d", nch, BW_MAX_NCH);
  end

  for (genvar c = 0; c < int'(nch); c++) begin : g_chan
    localparam int unsigned LSB = chan_lsb(c, width);

    bypass_wire_chan #(
      .width  (width),
      .stages (stages),
      .hold   (hold),
      .init   (init)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .wset  (bus.wset[c]),
      .wval  (bus.wval[LSB +: width]),
      .wget  (bus.wget[LSB +: width]),
      .whas  (bus.whas[c]),
      .wchg  (bus.wchg[c])
    );
  end

endmodule
